s4ga_cfg_player: RTL and testbench
==================================

Name: s4ga_cfg_player

Overview:
- Upstream feeder for the s4ga LUT-evaluation core.
- Holds one complete FPGA configuration: N LUT frames of LL segments each, SI_W bits per segment.
- A host loads the configuration once over a valid/ready segment stream. The block then replays it to the core's `si` input, one segment per clock, endlessly.
- Generates the core's synchronous active-high reset, held for at least N+1 cycles before replay starts, and flags each completed pass (one full FPGA evaluation).

Parameters:
- N, 73, number of LUTs; must not be a multiple of LL.
- K, 5, LUT inputs.
- SI_W, 4, segment width.
- Derived N_W = clog2(N).
- Derived IDX_SEGS = ceil(N_W/SI_W).
- Derived MASK_SEGS = ceil(2**K/SI_W).
- Derived LL = K*IDX_SEGS + MASK_SEGS.
- Derived DEPTH = N*LL.
- Derived A_W = clog2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- cfg_start  in  1  single-cycle pulse; begin (re)loading at segment 0.
- cfg_valid  in  1  cfg_seg valid.
- cfg_ready  out  1  block accepts cfg_seg this cycle.
- cfg_seg  in  SI_W  configuration segment, in frame order (LUT 0 seg 0 first).
- halt  in  1  request stop at the end of the current pass.
- si  out  SI_W  registered segment stream to the core.
- s_rst  out  1  registered synchronous reset to the core, active-high.
- running  out  1  high while in RUN.
- pass_done  out  1  one-cycle pulse coincident with the last segment (DEPTH-1) of each pass.

Behaviour:
- Storage: DEPTH x SI_W single-port synchronous RAM or register array, with 1-cycle read latency. `si` is taken from the registered read data.
- Async reset (rst_n=0): state=IDLE, addr=0, cnt=0, si=0, s_rst=1, cfg_ready=0, running=0, pass_done=0. Memory contents are not reset.
- FSM states: IDLE, LOAD, FLUSH, RUN.
- IDLE:
  - s_rst=1, si=0, cfg_ready=0.
  - cfg_start -> LOAD, addr=0.
- LOAD:
  - cfg_ready=1, s_rst=1, si=0.
  - A transfer occurs when cfg_valid&&cfg_ready: mem[addr]=cfg_seg, addr++.
  - The transfer at addr==DEPTH-1 -> FLUSH, addr=0, cnt=0.
  - cfg_valid=0 stalls indefinitely with no timeout.
  - cfg_start in LOAD restarts at addr=0; a transfer in the same cycle is discarded.
- FLUSH:
  - s_rst=1, cfg_ready=0, lasts exactly N+1 cycles (cnt 0..N).
  - In the cycle cnt==N, the read of mem[0] is issued, so the first RUN cycle presents si=mem[0] with s_rst=0.
- RUN:
  - s_rst=0, running=1. On each cycle si=mem[addr_prev]; addr wraps DEPTH-1 -> 0 with no bubble.
  - pass_done=1 in the cycle si carries segment DEPTH-1.
  - The core consumes exactly one segment per clock; there is no backpressure.
- halt:
  - Sampled and latched at any time in RUN.
  - At the end of the pass (the cycle after pass_done) -> IDLE: s_rst=1, si=0, running=0, latch cleared.
  - halt outside RUN is ignored.
- cfg_start during FLUSH or RUN aborts immediately. Next cycle: LOAD, s_rst=1, running=0, pending halt cleared, addr=0.
- cfg_start and halt asserted together: cfg_start wins.
- Reload from IDLE rewrites all DEPTH segments. A partial load never enters RUN.
- s_rst is continuously high from reset or abort until the first RUN cycle, and is never low outside RUN.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
Use N=5, K=2, SI_W=4, giving LL=3 and DEPTH=15.

1. Reset then idle: rst_n low with random inputs, then release. Required: si=0, s_rst=1, cfg_ready=0, running=0 for 20 cycles with no cfg_start.
2. Load and run:
   - Stimulus: cfg_start, then 15 back-to-back segments with values 0x1..0xF.
   - Required during load: cfg_ready=1 for exactly the 15 transfers.
   - Required after the 15th transfer: s_rst=1 for exactly 6 more cycles.
   - Required in RUN: si=1,2,...,F, then wraps to 1; pass_done high on each si=F; s_rst=0 throughout.
3. Stalled load: insert cfg_valid=0 gaps between transfers. Required: addr does not advance during gaps, the final memory image is identical, and the RUN stream is unchanged.
4. Halt mid-pass: assert halt for 1 cycle while si=4. Required: the stream continues through si=F with pass_done=1. The next cycle gives s_rst=1, si=0, running=0.
5. Abort during RUN:
   - Stimulus: cfg_start while si=7, then load 15 segments of value 0xA.
   - Required: cfg_ready=1 the next cycle; s_rst never drops before the new FLUSH completes.
   - Required after FLUSH: si=A continuously.
6. Async reset mid-LOAD: drop rst_n after 7 transfers. Required: outputs return to reset values immediately without waiting for a clock; no RUN without a fresh full load.

Source files
------------

// File: rtl/s4ga_cfg_player.sv
// Configuration store and replay engine for the s4ga LUT core: loads one
// configuration over a valid/ready stream, then streams it to the core forever.
module s4ga_cfg_player #(
  parameter int N    = 73,
  parameter int K    = 5,
  parameter int SI_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [SI_W-1:0] cfg_seg,
  input  logic            halt,
  output logic [SI_W-1:0] si,
  output logic            s_rst,
  output logic            running,
  output logic            pass_done
);

  localparam int N_W       = $clog2(N);
  localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = ((1 << K) + SI_W - 1) / SI_W;
  localparam int LL        = K * IDX_SEGS + MASK_SEGS;
  localparam int DEPTH     = N * LL;
  localparam int A_W       = $clog2(DEPTH);
  localparam int C_W       = $clog2(N + 1);

  localparam logic [A_W-1:0] LAST    = A_W'(DEPTH - 1);
  localparam logic [C_W-1:0] CNT_END = C_W'(N);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  state_t          state_reg;
  logic [A_W-1:0]  addr_reg;
  logic [C_W-1:0]  cnt_reg;
  logic            halt_reg;
  logic [SI_W-1:0] mem [DEPTH];
  logic            mem_we;

  // A restart in LOAD discards any transfer presented in the same cycle.
  assign mem_we = (state_reg == LOAD) && cfg_valid && !cfg_start;

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_reg] <= cfg_seg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      halt_reg  <= 1'b0;
      si        <= '0;
      s_rst     <= 1'b1;
      cfg_ready <= 1'b0;
      running   <= 1'b0;
      pass_done <= 1'b0;
    end else begin
      pass_done <= 1'b0;
      if (cfg_start) begin
        state_reg <= LOAD;
        addr_reg  <= '0;
        halt_reg  <= 1'b0;
        si        <= '0;
        s_rst     <= 1'b1;
        cfg_ready <= 1'b1;
        running   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: ;
          LOAD: begin
            if (cfg_valid) begin
              if (addr_reg == LAST) begin
                state_reg <= FLUSH;
                addr_reg  <= '0;
                cnt_reg   <= '0;
                cfg_ready <= 1'b0;
              end else begin
                addr_reg <= addr_reg + A_W'(1);
              end
            end
          end
          FLUSH: begin
            // Last flush cycle issues the read of segment 0 so RUN starts with data.
            if (cnt_reg == CNT_END) begin
              state_reg <= RUN;
              si        <= mem[addr_reg];
              addr_reg  <= addr_reg + A_W'(1);
              s_rst     <= 1'b0;
              running   <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + C_W'(1);
            end
          end
          RUN: begin
            if (pass_done && (halt_reg || halt)) begin
              state_reg <= IDLE;
              addr_reg  <= '0;
              halt_reg  <= 1'b0;
              si        <= '0;
              s_rst     <= 1'b1;
              running   <= 1'b0;
            end else begin
              si        <= mem[addr_reg];
              pass_done <= (addr_reg == LAST);
              addr_reg  <= (addr_reg == LAST) ? '0 : addr_reg + A_W'(1);
              if (halt) halt_reg <= 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_s4ga_cfg_player.sv
// Randomised and directed bench for s4ga_cfg_player, checked every cycle
// against a stream-index model of the load / flush / replay behaviour.
module tb_s4ga_cfg_player;

  localparam int N     = 5;
  localparam int K     = 2;
  localparam int SI_W  = 4;
  localparam int DEPTH = 15;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_FLUSH = 2;
  localparam int M_RUN   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_start = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            halt = 1'b0;
  logic [SI_W-1:0] cfg_seg = '0;
  logic            cfg_ready;
  logic [SI_W-1:0] si;
  logic            s_rst;
  logic            running;
  logic            pass_done;

  s4ga_cfg_player #(.N(N), .K(K), .SI_W(SI_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_seg   (cfg_seg),
    .halt      (halt),
    .si        (si),
    .s_rst     (s_rst),
    .running   (running),
    .pass_done (pass_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: which phase we are in, how many segments loaded, how many flush
  // cycles elapsed, and the absolute index into the replayed stream.
  int         m_mode = M_IDLE;
  int         m_loaded = 0;
  int         m_flush = 0;
  int         m_run_t = 0;
  bit         m_halt = 0;
  logic [3:0] m_mem [DEPTH];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int exp_si;
    exp_si = (m_mode == M_RUN) ? int'(m_mem[m_run_t % DEPTH]) : 0;
    chk("si", int'(si), exp_si);
    chk("s_rst", int'(s_rst), (m_mode != M_RUN) ? 1 : 0);
    chk("cfg_ready", int'(cfg_ready), (m_mode == M_LOAD) ? 1 : 0);
    chk("running", int'(running), (m_mode == M_RUN) ? 1 : 0);
    chk("pass_done", int'(pass_done),
        (m_mode == M_RUN && (m_run_t % DEPTH) == DEPTH - 1) ? 1 : 0);
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_halt = 0;
    end else if (cfg_start) begin
      m_mode = M_LOAD;
      m_loaded = 0;
      m_halt = 0;
    end else begin
      case (m_mode)
        M_LOAD: if (cfg_valid) begin
          $display("xfer idx=%0d seg=0x%0h", m_loaded, cfg_seg);
          m_mem[m_loaded] = cfg_seg;
          m_loaded++;
          if (m_loaded == DEPTH) begin
            m_mode = M_FLUSH;
            m_flush = 0;
          end
        end
        M_FLUSH: begin
          m_flush++;
          if (m_flush == N + 1) begin
            m_mode = M_RUN;
            m_run_t = 0;
          end
        end
        M_RUN: begin
          if ((m_run_t % DEPTH) == DEPTH - 1 && (m_halt || halt)) begin
            m_mode = M_IDLE;
            m_halt = 0;
          end else begin
            if (halt) m_halt = 1;
            m_run_t++;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit cs, input bit cv, input logic [3:0] seg, input bit h);
    cfg_start = cs;
    cfg_valid = cv;
    cfg_seg   = seg;
    halt      = h;
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'h0, 0);
  endtask

  task automatic wait_si(input int v);
    for (int i = 0; i < 60 && int'(si) != v; i++) step(0, 0, 4'h0, 0);
    chk("wait_si", int'(si), v);
  endtask

  task automatic load_ramp(input bit gaps);
    step(1, 0, 4'h0, 0);
    for (int v = 1; v <= DEPTH; v++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) step(0, 0, 4'($urandom), 0);
      end
      step(0, 1, 4'(v), 0);
    end
  endtask

  initial begin
    int n;

    // 1: reset with random inputs, then quiet idle
    for (int i = 0; i < 5; i++)
      step(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
    rst_n = 1'b1;
    idle_steps(20);
    chk("idle_s_rst", int'(s_rst), 1);

    // 2: load 1..F back to back, then replay
    step(1, 0, 4'h0, 0);
    n = 0;
    for (int v = 1; v <= DEPTH; v++) begin
      if (cfg_ready) n++;
      step(0, 1, 4'(v), 0);
    end
    chk("ready_cycles", n, 15);
    chk("ready_after_load", int'(cfg_ready), 0);
    n = 0;
    if (s_rst) n++;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 4'h0, 0);
      if (!s_rst) break;
      n++;
    end
    chk("flush_cycles", n, 6);
    for (int i = 0; i < 17; i++) begin
      chk("lit_si", int'(si), (i % 15) + 1);
      chk("lit_pass_done", int'(pass_done), (i % 15 == 14) ? 1 : 0);
      step(0, 0, 4'h0, 0);
    end

    // 3: stalled reload (abort from RUN), same image expected
    load_ramp(1);
    idle_steps(6);
    chk("stall_first_si", int'(si), 1);
    idle_steps(20);

    // 4: halt pulse while si=4
    wait_si(4);
    step(0, 0, 4'h0, 1);
    for (int i = 0; i < 40 && !pass_done; i++) step(0, 0, 4'h0, 0);
    chk("halt_last_si", int'(si), 15);
    step(0, 0, 4'h0, 0);
    chk("halt_s_rst", int'(s_rst), 1);
    chk("halt_si", int'(si), 0);
    chk("halt_running", int'(running), 0);
    idle_steps(5);

    // 5: abort during RUN at si=7, reload all 0xA
    load_ramp(0);
    idle_steps(8);
    wait_si(7);
    step(1, 0, 4'h0, 0);
    chk("abort_ready", int'(cfg_ready), 1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 4'hA, 0);
    idle_steps(6);
    for (int i = 0; i < 20; i++) begin
      chk("abort_si", int'(si), 10);
      step(0, 0, 4'h0, 0);
    end

    // 6: async reset after 7 transfers of a new load
    step(1, 0, 4'h0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 4'(i), 0);
    #3;
    rst_n = 1'b0;
    m_mode = M_IDLE;
    m_halt = 0;
    #1;
    chk("arst_si", int'(si), 0);
    chk("arst_s_rst", int'(s_rst), 1);
    chk("arst_ready", int'(cfg_ready), 0);
    chk("arst_running", int'(running), 0);
    chk("arst_pass_done", int'(pass_done), 0);
    step(0, 1, 4'h3, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(0, 1'($urandom), 4'($urandom), 1'($urandom));

    // Randomised rounds: random image, gaps, restarts, halts and aborts
    for (int r = 0; r < 4; r++) begin
      step(1, 0, 4'h0, 0);
      for (int i = 0; i < 300 && m_mode == M_LOAD; i++)
        step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom));
      for (int i = 0; i < 60; i++)
        step(($urandom_range(0, 99) == 0), 1'($urandom), 4'($urandom), ($urandom_range(0, 24) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
